sdr_arbiter: RTL and testbench

Shares one `avalon_sdr` SDRAM transfer engine between `NREQ` client blocks, such as the triangle loader (reads) and the pixel writer (writes). Each client posts a read or write job with a base address and element count. The arbiter grants one job at a time and latches that job's parameters so they stay stable for the whole transfer. It then pulses the engine's start, waits for the engine's end pulse, and returns a per-client done pulse. The block sits between the clients and the engine's external interface.

---
 rtl/sdr_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_arbiter.sv
// Round-robin arbiter sharing one avalon_sdr transfer engine between NREQ clients.
// Define SDR_ARB_FIXED_PRIO_EN to switch to fixed lowest-index-wins priority.
module sdr_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_NREAD  = 64,
    parameter int MAX_NWRITE = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              req_wr,
    input  logic [32*NREQ-1:0]           req_baseaddr,
    input  logic [30*NREQ-1:0]           req_nelems,
    input  logic [32*MAX_NWRITE*NREQ-1:0] req_writedata,
    output logic [NREQ-1:0]              done,
    output logic [NREQ-1:0]              err,
    output logic [NREQ-1:0]              gnt,
    output logic [32*MAX_NREAD-1:0]      readdata,
    output logic [31:0]                  sdr_baseaddr,
    output logic [29:0]                  sdr_nelems,
    output logic [32*MAX_NWRITE-1:0]     sdr_writedata,
    output logic                         sdr_readstart,
    output logic                         sdr_writestart,
    input  logic [32*MAX_NREAD-1:0]      sdr_readdata,
    input  logic                         sdr_readend,
    input  logic                         sdr_writeend
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = 32 * MAX_NWRITE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_r;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            hold_wr;
    logic [31:0]     hold_base;
    logic [29:0]     hold_nelems;
    logic            err_flag;
    logic            reject;
    logic            end_seen;
`ifndef SDR_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   last;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef SDR_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
`else
        // Scan from the farthest offset down so the client just after last is chosen.
        for (int k = NREQ; k >= 1; k--) begin
            if (req[IW'((int'(last) + k) % NREQ)]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(last) + k) % NREQ);
            end
        end
`endif
    end

    assign reject   = (hold_nelems == '0) ||
                      (hold_wr ? (hold_nelems > 30'(MAX_NWRITE)) : (hold_nelems > 30'(MAX_NREAD)));
    assign end_seen = hold_wr ? sdr_writeend : sdr_readend;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = CHECK;
            CHECK:   state_nxt = reject ? DONE : ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (end_seen) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_r       <= '0;
            gnt_idx     <= '0;
            hold_wr     <= 1'b0;
            hold_base   <= '0;
            hold_nelems <= '0;
            err_flag    <= 1'b0;
`ifndef SDR_ARB_FIXED_PRIO_EN
            last        <= IW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    gnt_r       <= NREQ'(1) << win_idx;
                    gnt_idx     <= win_idx;
                    hold_wr     <= req_wr[win_idx];
                    hold_base   <= req_baseaddr[32*win_idx +: 32];
                    hold_nelems <= req_nelems[30*win_idx +: 30];
                    err_flag    <= 1'b0;
                end
                CHECK: err_flag <= reject;
                DONE: begin
                    gnt_r <= '0;
`ifndef SDR_ARB_FIXED_PRIO_EN
                    last  <= gnt_idx;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sdr_readstart  = 1'b0;
        sdr_writestart = 1'b0;
        done           = '0;
        err            = '0;
        case (state)
            ISSUE: begin
                sdr_readstart  = ~hold_wr;
                sdr_writestart = hold_wr;
            end
            DONE: begin
                done = gnt_r;
                err  = err_flag ? gnt_r : '0;
            end
            default: ;
        endcase
    end

    assign gnt           = gnt_r;
    assign sdr_baseaddr  = hold_base;
    assign sdr_nelems    = hold_nelems;
    assign sdr_writedata = (|gnt_r) ? req_writedata[WDW*gnt_idx +: WDW] : '0;
    assign readdata      = sdr_readdata;

endmodule

// File: tb/tb_sdr_arbiter.sv
// Self-checking bench for sdr_arbiter: a job-timeline model checked every cycle plus directed literals.
module tb_sdr_arbiter;
    localparam int NREQ = 4;
    localparam int MAXR = 64;
    localparam int MAXW = 64;
    localparam int WDW  = 32 * MAXW;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NREQ-1:0]          req, req_wr;
    logic [32*NREQ-1:0]       req_baseaddr;
    logic [30*NREQ-1:0]       req_nelems;
    logic [WDW*NREQ-1:0]      req_writedata;
    logic [NREQ-1:0]          done, err, gnt;
    logic [32*MAXR-1:0]       readdata, sdr_readdata;
    logic [31:0]              sdr_baseaddr;
    logic [29:0]              sdr_nelems;
    logic [WDW-1:0]           sdr_writedata;
    logic                     sdr_readstart, sdr_writestart, sdr_readend, sdr_writeend;

    sdr_arbiter #(.NREQ(NREQ), .MAX_NREAD(MAXR), .MAX_NWRITE(MAXW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr),
        .req_baseaddr(req_baseaddr), .req_nelems(req_nelems), .req_writedata(req_writedata),
        .done(done), .err(err), .gnt(gnt), .readdata(readdata),
        .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_writedata(sdr_writedata),
        .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
        .sdr_readdata(sdr_readdata), .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s @%0t: timed out waiting", name, $time);
    endtask

    // Job-timeline model: cycle numbers of grant and completion, not DUT states.
    int              cyc = 0;
    bit              model_valid = 0;
    bit              job = 0;
    int              j_owner, j_grant, j_done;
    bit              j_wr, j_rej;
    int              m_last = NREQ - 1;
    logic [31:0]     m_base = '0;
    logic [29:0]     m_n = '0;

    task automatic model_step();
        int w;
        if (reset) begin
            job = 0; m_last = NREQ - 1; m_base = '0; m_n = '0;
        end else if (job) begin
            if (j_done < 0 && cyc >= j_grant + 2 && (j_wr ? sdr_writeend : sdr_readend))
                j_done = cyc + 1;
            else if (j_done == cyc) begin
                job = 0; m_last = j_owner;
            end
        end else if (req != '0) begin
            w = -1;
`ifdef SDR_ARB_FIXED_PRIO_EN
            for (int i = 0; i < NREQ; i++) if (w < 0 && req[i]) w = i;
`else
            for (int k = 1; k <= NREQ; k++) if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
`endif
            job = 1; j_owner = w; j_wr = req_wr[w];
            m_base = req_baseaddr[32*w +: 32];
            m_n    = req_nelems[30*w +: 30];
            j_rej  = (m_n == 0) || (m_n > (j_wr ? MAXW : MAXR));
            j_grant = cyc + 1;
            j_done  = j_rej ? cyc + 2 : -1;
        end
        cyc++;
        model_valid = 1;
    endtask

    task automatic compare();
        logic [NREQ-1:0] eg;
        logic [WDW-1:0]  ewd;
        bit              at_done;
        eg      = job ? (NREQ'(1) << j_owner) : '0;
        at_done = job && (j_done == cyc);
        ewd     = job ? req_writedata[WDW*j_owner +: WDW] : '0;
        check("gnt", 64'(gnt), 64'(eg));
        check("done", 64'(done), at_done ? 64'(eg) : 64'd0);
        check("err", 64'(err), (at_done && j_rej) ? 64'(eg) : 64'd0);
        check("readstart", 64'(sdr_readstart), 64'(job && !j_rej && !j_wr && cyc == j_grant + 1));
        check("writestart", 64'(sdr_writestart), 64'(job && !j_rej && j_wr && cyc == j_grant + 1));
        check("baseaddr", 64'(sdr_baseaddr), 64'(m_base));
        check("nelems", 64'(sdr_nelems), 64'(m_n));
        check("writedata_eq", 64'(sdr_writedata == ewd), 64'd1);
        check("readdata_eq", 64'(readdata == sdr_readdata), 64'd1);
    endtask

    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(negedge clk); if (model_valid) compare(); end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_job(input int i, input bit wr, input logic [31:0] base, input logic [29:0] n);
        req_wr[i] = wr;
        req_baseaddr[32*i +: 32] = base;
        req_nelems[30*i +: 30] = n;
    endtask

    task automatic do_reset();
        req = '0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_gnt(output int owner);
        int n = 0;
        owner = -1;
        while (gnt == '0 && n < 30) begin tick(); n++; end
        if (gnt == '0) timeout("wait_gnt");
        else for (int i = 0; i < NREQ; i++) if (gnt[i]) owner = i;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!(sdr_readstart || sdr_writestart) && n < 30) begin tick(); n++; end
        if (!(sdr_readstart || sdr_writestart)) timeout("wait_start");
    endtask

    // Serve one accepted job: end pulse in the first BUSY cycle, drop req at done.
    task automatic serve(input bit rereq, output int owner);
        wait_gnt(owner);
        if (owner < 0) return;
        wait_start();
        tick();
        if (req_wr[owner]) sdr_writeend = 1'b1; else sdr_readend = 1'b1;
        tick();
        sdr_readend = 1'b0; sdr_writeend = 1'b0;
        check("serve_done", 64'(done), 64'(NREQ'(1) << owner));
        req[owner] = 1'b0;
        tick();
        if (rereq) req[owner] = 1'b1;
    endtask

    int             order [5];
    int             exp_order [5];
    int             owner;
    logic [31:0]    rec_base;
    logic [29:0]    rec_n;
    logic [WDW-1:0] rec_wd;

    initial begin
        reset = 1'b1; req = '0; req_wr = '0; req_baseaddr = '0; req_nelems = '0;
        sdr_readend = 1'b0; sdr_writeend = 1'b0;
        for (int w = 0; w < NREQ*MAXW; w++) req_writedata[32*w +: 32] = $urandom;
        for (int w = 0; w < MAXR; w++) sdr_readdata[32*w +: 32] = $urandom;
        tick(); tick();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_base", 64'(sdr_baseaddr), 64'd0);
        check("rst_start", 64'({sdr_readstart, sdr_writestart}), 64'd0);

        // Single read: req at edge 0, start in cycle 2, end in cycle 20, done in 21.
        reset = 1'b0;
        set_job(1, 1'b0, 32'h1000, 30'd4);
        req[1] = 1'b1;
        tick();
        check("t1_gnt_c1", 64'(gnt), 64'h2);
        tick();
        check("t1_rstart_c2", 64'(sdr_readstart), 64'd1);
        check("t1_base_c2", 64'(sdr_baseaddr), 64'h1000);
        for (int c = 2; c < 20; c++) tick();
        check("t1_nodone_c20", 64'(done), 64'd0);
        sdr_readend = 1'b1;
        for (int w = 0; w < MAXR; w++) sdr_readdata[32*w +: 32] = 32'hA000_0000 + w;
        tick();
        sdr_readend = 1'b0;
        check("t1_done_c21", 64'(done), 64'h2);
        check("t1_err_c21", 64'(err), 64'd0);
        check("t1_readdata", 64'(readdata[31:0]), 64'hA000_0000);
        req[1] = 1'b0;
        tick(); tick();

        // Round-robin (or fixed priority) with all four clients re-requesting.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_job(i, 1'b0, 32'h100 * i, 30'd4);
        req = '1;
        for (int j = 0; j < 5; j++) begin
`ifdef SDR_ARB_FIXED_PRIO_EN
            exp_order[j] = 0;
`else
            exp_order[j] = j % NREQ;
`endif
            serve(j < 4, owner);
            order[j] = owner;
            check("rr_order", 64'(order[j]), 64'(exp_order[j]));
        end
        req = '0;
        tick();

        // Rejected jobs: zero-length read and 65-word write; 64-word write is accepted.
        set_job(2, 1'b0, 32'h3000, 30'd0);
        req[2] = 1'b1;
        tick();
        check("rej0_gnt_c1", 64'(gnt), 64'h4);
        tick();
        check("rej0_done_c2", 64'(done), 64'h4);
        check("rej0_err_c2", 64'(err), 64'h4);
        check("rej0_nostart", 64'({sdr_readstart, sdr_writestart}), 64'd0);
        req[2] = 1'b0;
        tick();
        set_job(2, 1'b1, 32'h3100, 30'd65);
        req[2] = 1'b1;
        tick(); tick();
        check("rej65_done_c2", 64'(done), 64'h4);
        check("rej65_err_c2", 64'(err), 64'h4);
        req[2] = 1'b0;
        tick();
        set_job(1, 1'b1, 32'h3200, 30'd64);
        req[1] = 1'b1;
        tick(); tick();
        check("w64_wstart_c2", 64'(sdr_writestart), 64'd1);
        serve(1'b0, owner);

        // Stability: client 0 writes while client 3 toggles its idle parameters.
        set_job(0, 1'b1, 32'h2000, 30'd8);
        set_job(3, 1'b0, 32'h5555_5555, 30'd3);
        req[0] = 1'b1;
        tick(); tick();
        check("stab_wstart", 64'(sdr_writestart), 64'd1);
        check("stab_base_lit", 64'(sdr_baseaddr), 64'h2000);
        rec_base = sdr_baseaddr; rec_n = sdr_nelems; rec_wd = sdr_writedata;
        for (int c = 0; c < 6; c++) begin
            req_baseaddr[96 +: 32] = ~req_baseaddr[96 +: 32];
            req_nelems[90 +: 30] = req_nelems[90 +: 30] ^ 30'd1;
            if (c == 5) sdr_writeend = 1'b1;
            tick();
            check("stab_base", 64'(sdr_baseaddr), 64'(rec_base));
            check("stab_nelems", 64'(sdr_nelems), 64'(rec_n));
            check("stab_wdata", 64'(sdr_writedata == rec_wd), 64'd1);
        end
        sdr_writeend = 1'b0;
        check("stab_done", 64'(done), 64'h1);
        req[0] = 1'b0;
        tick();

        // Stray write end during a read job, then a stray end while idle.
        set_job(1, 1'b0, 32'h4000, 30'd2);
        req[1] = 1'b1;
        wait_gnt(owner);
        wait_start();
        tick();
        sdr_writeend = 1'b1;
        tick();
        sdr_writeend = 1'b0;
        check("stray_nodone1", 64'(done), 64'd0);
        tick();
        check("stray_nodone2", 64'(done), 64'd0);
        sdr_readend = 1'b1;
        tick();
        sdr_readend = 1'b0;
        check("stray_done", 64'(done), 64'h2);
        req[1] = 1'b0;
        tick();
        sdr_readend = 1'b1;
        tick();
        sdr_readend = 1'b0;
        tick();
        check("idle_end_gnt", 64'(gnt), 64'd0);

        // Reset while BUSY, then client 0 wins first.
        set_job(2, 1'b0, 32'h6000, 30'd4);
        req[2] = 1'b1;
        wait_gnt(owner);
        wait_start();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_gnt", 64'(gnt), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_base", 64'(sdr_baseaddr), 64'd0);
        check("mrst_nelems", 64'(sdr_nelems), 64'd0);
        check("mrst_start", 64'({sdr_readstart, sdr_writestart}), 64'd0);
        for (int i = 0; i < NREQ; i++) set_job(i, 1'b0, 32'h700 + i, 30'd4);
        req = '1;
        tick();
        check("mrst_first_gnt", 64'(gnt), 64'h1);

        req = '0;
        reset = 1'b1;
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
